cv32e41p_hwloop_bank: RTL and testbench
=======================================

# cv32e41p_hwloop_bank

Parametrised hardware-loop register bank for the ID/EX boundary of the core. It holds start address, end address and iteration counter for N_REGS loops, with configurable counter and address widths. Counters decrement on loop-back with zero-saturation. It produces per-loop active and done status, and a sticky error flag. A registered read port serves CSR reads. It sits between the EX-stage hwloop setup path, the hwloop controller (decrement requests) and the CSR file.

## Interface
- N_REGS, 2, number of hardware loops (>=1)
- CNT_WIDTH, 32, counter width (1..32)
- ADDR_WIDTH, 32, start/end address width (2..32)
- N_REG_BITS, (N_REGS>1 ? $clog2(N_REGS) : 1), loop-index width
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start_data_i  in  ADDR_WIDTH  start address write data
- end_data_i  in  ADDR_WIDTH  end address write data
- cnt_data_i  in  CNT_WIDTH  counter write data
- we_i  in  3  write enables: [0] start, [1] end, [2] counter
- regid_i  in  N_REG_BITS  target loop for writes
- valid_i  in  1  ID stage instruction valid; qualifies decrements
- dec_cnt_i  in  N_REGS  per-loop decrement request from hwloop controller
- flush_i  in  1  clear all counters
- err_clr_i  in  1  clear sticky error
- rd_req_i  in  1  read request
- rd_regid_i  in  N_REG_BITS  read loop index
- rd_sel_i  in  2  0 start, 1 end, 2 counter, 3 status
- rd_data_o  out  32  read data
- rd_valid_o  out  1  read data valid
- start_addr_o  out  N_REGS x ADDR_WIDTH  start registers
- end_addr_o  out  N_REGS x ADDR_WIDTH  end registers
- counter_o  out  N_REGS x CNT_WIDTH  counter registers
- active_o  out  N_REGS  counter_o[k] != 0
- done_o  out  N_REGS  one-cycle pulse, loop k finished
- err_o  out  1  sticky decrement error

## Operation
- Writes: each of we_i[0..2] updates the field of loop regid_i independently. Several fields may be written in the same cycle.
- regid_i >= N_REGS: the write is ignored and no state changes.
- Address writes force bit 0 to 0 (halfword alignment). All other bits are stored as given.
- Counter update priority per loop k: flush_i, then counter write (we_i[2] && regid_i==k), then decrement.
  - flush_i: counter <= 0 for every loop. Addresses are kept.
  - Write: counter <= cnt_data_i.
  - Decrement: dec_cnt_i[k] && valid_i && counter!=0 gives counter <= counter-1.
  - Decrement with counter==0: the counter holds at 0 (no wrap) and err_o sets.
- A decrement request that loses priority to a flush or write is dropped silently, with no error.
- More than one dec_cnt_i bit with valid_i: every requested loop decrements, and err_o sets.
- dec_cnt_i is ignored when valid_i=0.
- done_o[k] pulses for exactly one cycle after a decrement takes counter k from 1 to 0. A write or flush to 0 produces no pulse.
- active_o is combinational from the counter registers.
- err_o: set wins over err_clr_i in the same cycle. Otherwise err_clr_i clears it.
- Read port:
  - rd_data_o is registered and reflects state before any same-cycle write.
  - Addresses and counter are zero-extended to 32 bits.
  - sel 3 returns {29'b0, err_o, done_o[k], active_o[k]}.
  - rd_regid_i >= N_REGS returns 0.
  - rd_data_o holds its last value when no read is requested.

## Timing
- Reset: all start, end and counter registers = 0; active_o=0, done_o=0, err_o=0, rd_valid_o=0, rd_data_o=0.
- Write and decrement effects are visible on outputs the cycle after the edge that samples them.
- done_o, err_o and rd_data_o are registered with 1-cycle latency. rd_valid_o = rd_req_i delayed one cycle.
- Back-to-back reads are allowed every cycle. There is no backpressure.
- Reset asserted mid-loop returns all state to reset values immediately, and no done_o pulse is generated.

## Test plan
- Reset, then write loop1 start=0x101, end=0x200, cnt=3 in one cycle. Expect start_addr_o[1]=0x100, end_addr_o[1]=0x200, counter_o[1]=3, active_o[1]=1.
- Three decrements of loop1 with valid_i=1. Expect counter 2, 1, 0, a single done_o[1] pulse the cycle after reaching 0, active_o[1]=0, err_o=0.
- Decrement loop0 with counter 0. Expect counter stays 0 and err_o=1. err_clr_i alone clears it; err_clr_i together with a new error keeps it at 1.
- Write cnt=5 to loop0 in the same cycle as dec_cnt_i[0] with valid_i=1. Expect counter 5, no error. flush_i together with a write: expect counter 0, no done_o.
- dec_cnt_i=2'b11 with both counters 4. Expect both become 3 and err_o=1. Same request with valid_i=0: expect no change.
- Read sequence sel 0..3 for loop1 with the CNT_WIDTH=16, N_REGS=3 configuration. Expect values one cycle later with rd_valid_o, zero-extended counter, and status bits correct. rd_regid_i=3 returns 0.

Source files
------------

// File: rtl/cv32e41p_hwloop_bank.sv
// Hardware-loop register bank: start/end/counter per loop, zero-saturating
// decrement, one-cycle done pulses, sticky error flag and a registered read port.

// Per-loop state: halfword-aligned addresses, counter with flush > write > decrement.
module cv32e41p_hwloop_lane #(
  parameter int CNT_WIDTH  = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sel,
  input  logic [2:0]            we,
  input  logic [ADDR_WIDTH-1:0] start_data,
  input  logic [ADDR_WIDTH-1:0] end_data,
  input  logic [CNT_WIDTH-1:0]  cnt_data,
  input  logic                  flush,
  input  logic                  dec,
  output logic [ADDR_WIDTH-1:0] start_addr,
  output logic [ADDR_WIDTH-1:0] end_addr,
  output logic [CNT_WIDTH-1:0]  counter,
  output logic                  done,
  output logic                  dec_err
);

  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(1);

  logic wr_cnt;
  logic dec_eff;

  // A decrement only takes effect when neither flush nor a counter write wins.
  always_comb begin
    wr_cnt  = sel && we[2];
    dec_eff = dec && !flush && !wr_cnt;
    dec_err = dec_eff && (counter == '0);
  end

  // Address registers; bit 0 always stored as 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_addr <= '0;
      end_addr   <= '0;
    end else begin
      if (sel && we[0]) start_addr <= start_data & ALIGN_MASK;
      if (sel && we[1]) end_addr   <= end_data & ALIGN_MASK;
    end
  end

  // Counter with saturation at zero, plus done pulse on the 1 -> 0 decrement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      counter <= '0;
      done    <= 1'b0;
    end else begin
      done <= dec_eff && (counter == CNT_WIDTH'(1));
      if (flush)                          counter <= '0;
      else if (wr_cnt)                    counter <= cnt_data;
      else if (dec_eff && counter != '0)  counter <= counter - CNT_WIDTH'(1);
    end
  end

endmodule

module cv32e41p_hwloop_bank #(
  parameter int N_REGS     = 2,
  parameter int CNT_WIDTH  = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int N_REG_BITS = (N_REGS > 1) ? $clog2(N_REGS) : 1
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [ADDR_WIDTH-1:0]                 start_data_i,
  input  logic [ADDR_WIDTH-1:0]                 end_data_i,
  input  logic [CNT_WIDTH-1:0]                  cnt_data_i,
  input  logic [2:0]                            we_i,
  input  logic [N_REG_BITS-1:0]                 regid_i,
  input  logic                                  valid_i,
  input  logic [N_REGS-1:0]                     dec_cnt_i,
  input  logic                                  flush_i,
  input  logic                                  err_clr_i,
  input  logic                                  rd_req_i,
  input  logic [N_REG_BITS-1:0]                 rd_regid_i,
  input  logic [1:0]                            rd_sel_i,
  output logic [31:0]                           rd_data_o,
  output logic                                  rd_valid_o,
  output logic [N_REGS-1:0][ADDR_WIDTH-1:0]     start_addr_o,
  output logic [N_REGS-1:0][ADDR_WIDTH-1:0]     end_addr_o,
  output logic [N_REGS-1:0][CNT_WIDTH-1:0]      counter_o,
  output logic [N_REGS-1:0]                     active_o,
  output logic [N_REGS-1:0]                     done_o,
  output logic                                  err_o
);

  logic [N_REGS-1:0] dec_req;
  logic [N_REGS-1:0] lane_err;
  logic              multi_dec;
  logic              err_set;
  logic [31:0]       rd_word;

  for (genvar k = 0; k < N_REGS; k++) begin : g_lane
    cv32e41p_hwloop_lane #(
      .CNT_WIDTH  (CNT_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
    ) u_lane (
      .clk        (clk),
      .rst_n      (rst_n),
      .sel        (regid_i == N_REG_BITS'(k)),
      .we         (we_i),
      .start_data (start_data_i),
      .end_data   (end_data_i),
      .cnt_data   (cnt_data_i),
      .flush      (flush_i),
      .dec        (dec_req[k]),
      .start_addr (start_addr_o[k]),
      .end_addr   (end_addr_o[k]),
      .counter    (counter_o[k]),
      .done       (done_o[k]),
      .dec_err    (lane_err[k])
    );
    assign active_o[k] = (counter_o[k] != '0);
  end

  // Decrement qualification and error sources (underflow or simultaneous requests).
  always_comb begin
    dec_req   = valid_i ? dec_cnt_i : '0;
    multi_dec = (dec_req & (dec_req - N_REGS'(1))) != '0;
    err_set   = (|lane_err) || multi_dec;
  end

  // Sticky error: a new error wins over clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         err_o <= 1'b0;
    else if (err_set)   err_o <= 1'b1;
    else if (err_clr_i) err_o <= 1'b0;
  end

  // Read mux over current (pre-write) state, zero-extended; out-of-range index reads 0.
  always_comb begin
    rd_word = '0;
    if (32'(rd_regid_i) < N_REGS) begin
      case (rd_sel_i)
        2'd0:    rd_word = 32'(start_addr_o[rd_regid_i]);
        2'd1:    rd_word = 32'(end_addr_o[rd_regid_i]);
        2'd2:    rd_word = 32'(counter_o[rd_regid_i]);
        default: rd_word = {29'b0, err_o, done_o[rd_regid_i], active_o[rd_regid_i]};
      endcase
    end
  end

  // Registered read port; data holds when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_o <= 1'b0;
      rd_data_o  <= '0;
    end else begin
      rd_valid_o <= rd_req_i;
      if (rd_req_i) rd_data_o <= rd_word;
    end
  end

endmodule

// File: tb/tb_cv32e41p_hwloop_bank.sv
// Directed bench for cv32e41p_hwloop_bank (3 loops, 16-bit counters).
module tb_cv32e41p_hwloop_bank;

  localparam int N  = 3;
  localparam int CW = 16;
  localparam int AW = 32;
  localparam int RB = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [AW-1:0]     start_data_i, end_data_i;
  logic [CW-1:0]     cnt_data_i;
  logic [2:0]        we_i;
  logic [RB-1:0]     regid_i, rd_regid_i;
  logic              valid_i, flush_i, err_clr_i, rd_req_i;
  logic [N-1:0]      dec_cnt_i;
  logic [1:0]        rd_sel_i;
  logic [31:0]       rd_data_o;
  logic              rd_valid_o, err_o;
  logic [N-1:0][AW-1:0] start_addr_o, end_addr_o;
  logic [N-1:0][CW-1:0] counter_o;
  logic [N-1:0]      active_o, done_o;

  int n_cmp = 0;
  int n_bad = 0;

  cv32e41p_hwloop_bank #(.N_REGS(N), .CNT_WIDTH(CW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .start_data_i(start_data_i), .end_data_i(end_data_i), .cnt_data_i(cnt_data_i),
    .we_i(we_i), .regid_i(regid_i), .valid_i(valid_i), .dec_cnt_i(dec_cnt_i),
    .flush_i(flush_i), .err_clr_i(err_clr_i), .rd_req_i(rd_req_i),
    .rd_regid_i(rd_regid_i), .rd_sel_i(rd_sel_i), .rd_data_o(rd_data_o),
    .rd_valid_o(rd_valid_o), .start_addr_o(start_addr_o), .end_addr_o(end_addr_o),
    .counter_o(counter_o), .active_o(active_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we_i = '0; valid_i = 0; dec_cnt_i = '0; flush_i = 0; err_clr_i = 0;
    rd_req_i = 0;
  endtask

  task automatic wr_cnt(input logic [RB-1:0] id, input logic [CW-1:0] v);
    idle(); regid_i = id; we_i = 3'b100; cnt_data_i = v; tick(); idle();
  endtask

  initial begin
    idle();
    rst_n = 0; start_data_i = '0; end_data_i = '0; cnt_data_i = '0;
    regid_i = '0; rd_regid_i = '0; rd_sel_i = '0;
    repeat (3) tick();
    chk("rst_cnt1", 32'(counter_o[1]), 0);
    chk("rst_start1", start_addr_o[1], 0);
    chk("rst_active", 32'(active_o), 0);
    chk("rst_done", 32'(done_o), 0);
    chk("rst_err", 32'(err_o), 0);
    chk("rst_rdv", 32'(rd_valid_o), 0);
    chk("rst_rdd", rd_data_o, 0);
    rst_n = 1; tick();

    // Write all three fields of loop1 at once
    regid_i = 1; we_i = 3'b111; start_data_i = 32'h101; end_data_i = 32'h200; cnt_data_i = 3;
    tick(); idle();
    chk("wr_start1", start_addr_o[1], 32'h100);
    chk("wr_end1", end_addr_o[1], 32'h200);
    chk("wr_cnt1", 32'(counter_o[1]), 3);
    chk("wr_active1", 32'(active_o[1]), 1);

    // Three decrements of loop1
    valid_i = 1; dec_cnt_i = 3'b010;
    tick(); chk("dec_cnt2", 32'(counter_o[1]), 2); chk("dec_done_a", 32'(done_o), 0);
    tick(); chk("dec_cnt1", 32'(counter_o[1]), 1); chk("dec_done_b", 32'(done_o), 0);
    tick(); chk("dec_cnt0", 32'(counter_o[1]), 0); chk("dec_done_pulse", 32'(done_o), 3'b010);
    idle(); tick();
    chk("dec_done_gone", 32'(done_o), 0);
    chk("dec_inactive", 32'(active_o[1]), 0);
    chk("dec_no_err", 32'(err_o), 0);

    // Underflow on loop0 and sticky error handling
    valid_i = 1; dec_cnt_i = 3'b001; tick(); idle();
    chk("uf_cnt0", 32'(counter_o[0]), 0);
    chk("uf_err", 32'(err_o), 1);
    err_clr_i = 1; tick(); idle();
    chk("clr_err", 32'(err_o), 0);
    err_clr_i = 1; valid_i = 1; dec_cnt_i = 3'b001; tick(); idle();
    chk("set_wins", 32'(err_o), 1);
    err_clr_i = 1; tick(); idle();

    // Write beats decrement, silently
    regid_i = 0; we_i = 3'b100; cnt_data_i = 5; valid_i = 1; dec_cnt_i = 3'b001;
    tick(); idle();
    chk("wr_over_dec", 32'(counter_o[0]), 5);
    chk("wr_over_dec_err", 32'(err_o), 0);
    // Flush beats write
    flush_i = 1; regid_i = 0; we_i = 3'b100; cnt_data_i = 7; tick(); idle();
    chk("flush_cnt0", 32'(counter_o[0]), 0);
    chk("flush_done", 32'(done_o), 0);
    chk("flush_keep_addr", start_addr_o[1], 32'h100);

    // Two simultaneous decrements
    wr_cnt(0, 4); wr_cnt(1, 4);
    valid_i = 1; dec_cnt_i = 3'b011; tick(); idle();
    chk("multi_cnt0", 32'(counter_o[0]), 3);
    chk("multi_cnt1", 32'(counter_o[1]), 3);
    chk("multi_err", 32'(err_o), 1);
    err_clr_i = 1; tick(); idle();
    valid_i = 0; dec_cnt_i = 3'b011; tick(); idle();
    chk("novalid_cnt0", 32'(counter_o[0]), 3);
    chk("novalid_cnt1", 32'(counter_o[1]), 3);
    chk("novalid_err", 32'(err_o), 0);

    // Out-of-range write index changes nothing
    regid_i = 3; we_i = 3'b111; start_data_i = 32'h44; end_data_i = 32'h88; cnt_data_i = 9;
    tick(); idle();
    chk("oor_cnt2", 32'(counter_o[2]), 0);
    chk("oor_start2", start_addr_o[2], 0);
    chk("oor_cnt0", 32'(counter_o[0]), 3);

    // Read port
    wr_cnt(1, 16'hABC);
    rd_req_i = 1; rd_regid_i = 1; rd_sel_i = 0; tick();
    chk("rd_start_v", 32'(rd_valid_o), 1);
    chk("rd_start", rd_data_o, 32'h100);
    rd_sel_i = 1; tick(); chk("rd_end", rd_data_o, 32'h200);
    rd_sel_i = 2; regid_i = 1; we_i = 3'b100; cnt_data_i = 5; tick(); we_i = '0;
    chk("rd_cnt_prewrite", rd_data_o, 32'h0ABC);
    rd_sel_i = 3; tick(); chk("rd_status", rd_data_o, 32'h1);
    rd_regid_i = 3; tick(); chk("rd_oor", rd_data_o, 0);
    rd_regid_i = 1; rd_sel_i = 0; tick();
    rd_req_i = 0; tick();
    chk("rd_idle_v", 32'(rd_valid_o), 0);
    chk("rd_hold", rd_data_o, 32'h100);

    // Reset asserted mid-loop
    wr_cnt(1, 1);
    valid_i = 1; dec_cnt_i = 3'b010; rst_n = 0; tick(); idle();
    chk("mrst_cnt1", 32'(counter_o[1]), 0);
    chk("mrst_done", 32'(done_o), 0);
    chk("mrst_start1", start_addr_o[1], 0);
    rst_n = 1; tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
